// File: rtl/dram_sdp_wr_arbiter_pkg.sv
// Shared types, default sizes and the clogb2 helper for the DRAM_SDP write arbiter.
package dram_sdp_wr_arbiter_pkg;

    localparam int unsigned RAM_WIDTH_DEF = 32;
    localparam int unsigned RAM_DEPTH_DEF = 64;
    localparam int unsigned MAX_BURST_DEF = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        PRI_STORE  = 1'b0,
        PRI_REFILL = 1'b1
    } arb_pri_t;

    // Number of bits needed to hold 'value' (same convention as DRAM_SDP).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned n;
        v = value;
        n = 0;
        while (v > 0) begin
            n = n + 1;
            v = v >> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/dram_sdp_wr_arbiter_if.sv
// Store and refill request/handshake bundle between the LSU/refill FSM and the arbiter.
interface dram_sdp_wr_arbiter_if #(
    parameter int unsigned AW = 6,
    parameter int unsigned LW = 4,
    parameter int unsigned W  = 32
);
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [W-1:0]  st_data;

    logic          rf_req;
    logic          rf_ack;
    logic [AW-1:0] rf_addr;
    logic [LW-1:0] rf_len;
    logic          rf_valid;
    logic          rf_ready;
    logic [W-1:0]  rf_data;
    logic          rf_done;

    modport master (
        output st_valid, st_addr, st_data,
        output rf_req, rf_addr, rf_len, rf_valid, rf_data,
        input  st_ready, rf_ack, rf_ready, rf_done
    );

    modport slave (
        input  st_valid, st_addr, st_data,
        input  rf_req, rf_addr, rf_len, rf_valid, rf_data,
        output st_ready, rf_ack, rf_ready, rf_done
    );
endinterface

// File: rtl/dram_sdp_wr_arbiter_rr_arb2.sv
// Two-requester round-robin pick (store vs refill) with its priority flop.
module dram_sdp_wr_arbiter_rr_arb2
    import dram_sdp_wr_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_st_i,
    input  logic req_rf_i,
    output logic gnt_st_o,
    output logic gnt_rf_o
);

    arb_pri_t pri_q, pri_d;

    // Grant one requester; ties go to pri, and pri moves to the other side after any grant.
    always_comb begin
        gnt_st_o = en_i && req_st_i && (!req_rf_i || (pri_q == PRI_STORE));
        gnt_rf_o = en_i && req_rf_i && (!req_st_i || (pri_q == PRI_REFILL));
        pri_d    = pri_q;
        if (gnt_st_o) begin
            pri_d = PRI_REFILL;
        end else if (gnt_rf_o) begin
            pri_d = PRI_STORE;
        end
    end

    // Priority register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_q <= PRI_STORE;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule

// File: rtl/dram_sdp_wr_arbiter.sv
// Write-port arbiter in front of a DRAM_SDP: store vs multi-beat refill, registered
// write command, asynchronous read pass-through.
// Optional: define DRAM_WR_BYPASS_EN to forward the pending registered write to rd_data.
module dram_sdp_wr_arbiter
    import dram_sdp_wr_arbiter_pkg::*;
#(
    parameter  int unsigned RAM_WIDTH = RAM_WIDTH_DEF,
    parameter  int unsigned RAM_DEPTH = RAM_DEPTH_DEF,
    parameter  int unsigned MAX_BURST = MAX_BURST_DEF,
    localparam int unsigned AW        = clogb2(RAM_DEPTH - 1),
    localparam int unsigned LW        = clogb2(MAX_BURST - 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    dram_sdp_wr_arbiter_if.slave bus,
    output logic                 busy,
    output logic [AW-1:0]        ram_addr_w,
    output logic [RAM_WIDTH-1:0] ram_din_w,
    output logic                 ram_we_w,
    input  logic [AW-1:0]        rd_addr,
    output logic [AW-1:0]        ram_addr_r,
    input  logic [RAM_WIDTH-1:0] ram_dout_r,
    output logic [RAM_WIDTH-1:0] rd_data
);

    arb_state_t           state_q, state_d;
    logic [LW-1:0]        cnt_q, cnt_d;
    logic [LW-1:0]        len_q, len_d;
    logic [AW-1:0]        base_q, base_d;

    logic                 arb_en, gnt_st, gnt_rf;
    logic                 st_hs, rf_hs, last_beat;
    logic [AW-1:0]        beat_addr;

    logic                 we_q;
    logic [AW-1:0]        waddr_q;
    logic [RAM_WIDTH-1:0] wdata_q;
    logic                 done_q;

    // Grants are only offered from IDLE and never while reset is held.
    assign arb_en = !rst && (state_q == ARB_IDLE);

    dram_sdp_wr_arbiter_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .en_i     (arb_en),
        .req_st_i (bus.st_valid),
        .req_rf_i (bus.rf_req),
        .gnt_st_o (gnt_st),
        .gnt_rf_o (gnt_rf)
    );

    // Wrap past the last entry is plain AW-bit truncation.
    assign beat_addr = base_q + AW'(cnt_q);

    // FSM state and burst bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            base_q  <= base_d;
        end
    end

    // Next state: accept a burst from IDLE, count beats, leave on the final beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        base_d  = base_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_rf) begin
                    base_d  = bus.rf_addr;
                    len_d   = bus.rf_len;
                    cnt_d   = '0;
                    state_d = ARB_BURST;
                end
            end
            ARB_BURST: begin
                if (rf_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Handshake outputs and the write handshakes they imply.
    always_comb begin
        bus.st_ready = gnt_st;
        bus.rf_ack   = gnt_rf;
        bus.rf_ready = !rst && (state_q == ARB_BURST);
        busy         = (state_q == ARB_BURST);
        st_hs        = bus.st_valid && gnt_st;
        rf_hs        = bus.rf_valid && bus.rf_ready;
        last_beat    = rf_hs && (cnt_q == len_q);
    end

    // Registered write command: one cycle after the handshake; address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= st_hs || rf_hs;
            done_q <= last_beat;
            if (st_hs) begin
                waddr_q <= bus.st_addr;
                wdata_q <= bus.st_data;
            end else if (rf_hs) begin
                waddr_q <= beat_addr;
                wdata_q <= bus.rf_data;
            end
        end
    end

    assign ram_we_w    = we_q;
    assign ram_addr_w  = waddr_q;
    assign ram_din_w   = wdata_q;
    assign bus.rf_done = done_q;

    assign ram_addr_r = rd_addr;

`ifdef DRAM_WR_BYPASS_EN
    assign rd_data = (we_q && (waddr_q == rd_addr)) ? wdata_q : ram_dout_r;
`else
    assign rd_data = ram_dout_r;
`endif

endmodule

// File: tb/tb_dram_sdp_wr_arbiter.sv
// Bench for dram_sdp_wr_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (remaining-beat counter, modulo addressing, expected RAM image).
module tb_dram_sdp_wr_arbiter;
    import dram_sdp_wr_arbiter_pkg::*;

    localparam int W  = 32;
    localparam int D  = 64;
    localparam int MB = 16;
    localparam int AW = clogb2(D - 1);
    localparam int LW = clogb2(MB - 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dram_sdp_wr_arbiter_if #(.AW(AW), .LW(LW), .W(W)) bus ();

    logic          busy, ram_we_w;
    logic [AW-1:0] ram_addr_w, rd_addr, ram_addr_r;
    logic [W-1:0]  ram_din_w, ram_dout_r, rd_data;

    dram_sdp_wr_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .ram_addr_w (ram_addr_w),
        .ram_din_w  (ram_din_w),
        .ram_we_w   (ram_we_w),
        .rd_addr    (rd_addr),
        .ram_addr_r (ram_addr_r),
        .ram_dout_r (ram_dout_r),
        .rd_data    (rd_data)
    );

    // DRAM_SDP stand-in: synchronous write, asynchronous read.
    logic [W-1:0] ram [D];
    always @(posedge clk) if (ram_we_w) ram[ram_addr_w] <= ram_din_w;
    assign ram_dout_r = ram[ram_addr_r];

    // Reference model state.
    bit           m_burst, m_store_first, m_pend, m_done;
    int           m_left, m_next;
    logic [AW-1:0] m_wa;
    logic [W-1:0]  m_wd;
    logic [W-1:0]  exp_mem [D];

    int total = 0;
    int bad   = 0;
    logic [AW-1:0] wq [$];
    int done_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_burst = 0; m_store_first = 1; m_pend = 0; m_done = 0;
        m_left = 0; m_next = 0; m_wa = '0; m_wd = '0;
    endtask

    task automatic check_all();
        bit es, ea;
        logic [W-1:0] er;
        es = !rst && !m_burst && bus.st_valid && (!bus.rf_req || m_store_first);
        ea = !rst && !m_burst && bus.rf_req && (!bus.st_valid || !m_store_first);
        er = exp_mem[rd_addr];
`ifdef DRAM_WR_BYPASS_EN
        if (m_pend && m_wa == rd_addr) er = m_wd;
`endif
        chk("st_ready", 32'(bus.st_ready), 32'(es));
        chk("rf_ack", 32'(bus.rf_ack), 32'(ea));
        chk("rf_ready", 32'(bus.rf_ready), 32'(!rst && m_burst));
        chk("busy", 32'(busy), 32'(m_burst));
        chk("ram_we_w", 32'(ram_we_w), 32'(m_pend));
        chk("ram_addr_w", 32'(ram_addr_w), 32'(m_wa));
        chk("ram_din_w", ram_din_w, m_wd);
        chk("rf_done", 32'(bus.rf_done), 32'(m_done));
        chk("ram_addr_r", 32'(ram_addr_r), 32'(rd_addr));
        chk("rd_data", rd_data, er);
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic model_step();
        bit st_hs, ack, rf_hs;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_pend) exp_mem[m_wa] = m_wd;
        st_hs = !m_burst && bus.st_valid && (!bus.rf_req || m_store_first);
        ack   = !m_burst && bus.rf_req && (!bus.st_valid || !m_store_first);
        rf_hs = m_burst && bus.rf_valid;
        m_pend = st_hs || rf_hs;
        m_done = 0;
        if (st_hs) begin
            m_wa = bus.st_addr; m_wd = bus.st_data; m_store_first = 0;
        end else if (ack) begin
            m_burst = 1; m_left = int'(bus.rf_len) + 1; m_next = int'(bus.rf_addr);
            m_store_first = 1;
        end else if (rf_hs) begin
            m_wa = AW'(m_next); m_wd = bus.rf_data;
            m_next = (m_next + 1) % D;
            m_left--;
            if (m_left == 0) begin m_burst = 0; m_done = 1; end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_we", 32'(ram_we_w), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(bus.rf_done), 32'd0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit pat [6];
        rst = 1'b0;
        bus.st_valid = 0; bus.st_addr = '0; bus.st_data = '0;
        bus.rf_req = 0; bus.rf_addr = '0; bus.rf_len = '0;
        bus.rf_valid = 0; bus.rf_data = '0; rd_addr = '0;
        for (int i = 0; i < D; i++) begin
            ram[i] = W'(i) * 32'h0101_0101;
            exp_mem[i] = W'(i) * 32'h0101_0101;
        end
        model_reset();
        #1 rst = 1'b1;
        bus.st_valid = 1; bus.rf_req = 1;
        @(posedge clk); #1;
        chk("init_we", 32'(ram_we_w), 32'd0);
        chk("init_addr", 32'(ram_addr_w), 32'd0);
        chk("init_din", ram_din_w, 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_st_ready", 32'(bus.st_ready), 32'd0);
        chk("init_rf_ack", 32'(bus.rf_ack), 32'd0);
        cycle();
        rst = 1'b0; bus.st_valid = 0; bus.rf_req = 0;

        // Single store and readback, with same-cycle read of the pending address.
        bus.st_valid = 1; bus.st_addr = AW'(5); bus.st_data = 32'hDEAD_BEEF; rd_addr = AW'(5);
        #1 chk("store_ready", 32'(bus.st_ready), 32'd1);
        cycle();
        bus.st_valid = 0;
        #1;
        chk("store_we", 32'(ram_we_w), 32'd1);
        chk("store_addr", 32'(ram_addr_w), 32'd5);
        chk("store_din", ram_din_w, 32'hDEAD_BEEF);
`ifdef DRAM_WR_BYPASS_EN
        chk("store_fwd", rd_data, 32'hDEAD_BEEF);
`else
        chk("store_old", rd_data, 32'h0505_0505);
`endif
        cycle();
        chk("store_readback", rd_data, 32'hDEAD_BEEF);
        bus.st_valid = 1; bus.st_addr = AW'(7); bus.st_data = 32'h0000_00A5;
        cycle();
        bus.st_valid = 0; rd_addr = AW'(7);
        #1;
`ifdef DRAM_WR_BYPASS_EN
        chk("bypass_a5", rd_data, 32'h0000_00A5);
`else
        chk("nobypass_old", rd_data, 32'h0707_0707);
`endif
        cycle();
        chk("a5_readback", rd_data, 32'h0000_00A5);

        // Tie from reset, then a wrapping burst with gaps while a store waits.
        do_reset();
        bus.st_valid = 1; bus.st_addr = AW'(10); bus.st_data = 32'h1111;
        bus.rf_req = 1; bus.rf_addr = AW'(62); bus.rf_len = LW'(3);
        #1;
        chk("tie1_st", 32'(bus.st_ready), 32'd1);
        chk("tie1_rf", 32'(bus.rf_ack), 32'd0);
        cycle();
        bus.st_data = 32'h2222;
        #1;
        chk("tie2_rf", 32'(bus.rf_ack), 32'd1);
        chk("tie2_st", 32'(bus.st_ready), 32'd0);
        cycle();
        pat = '{1, 0, 0, 1, 1, 1};
        k = 0; done_cnt = 0; wq.delete();
        for (int i = 0; i < 6; i++) begin
            bus.rf_valid = pat[i]; bus.rf_data = 32'h10 + k;
            #1 chk("burst_st_blocked", 32'(bus.st_ready), 32'd0);
            cycle();
            if (pat[i]) k++;
            if (ram_we_w) wq.push_back(ram_addr_w);
            if (bus.rf_done) done_cnt++;
        end
        bus.rf_valid = 0;
        chk("wrap_count", 32'(wq.size()), 32'd4);
        if (wq.size() == 4) begin
            chk("wrap_a0", 32'(wq[0]), 32'd62);
            chk("wrap_a1", 32'(wq[1]), 32'd63);
            chk("wrap_a2", 32'(wq[2]), 32'd0);
            chk("wrap_a3", 32'(wq[3]), 32'd1);
        end
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("done_with_we", 32'(ram_we_w), 32'd1);
        chk("after_tie_st", 32'(bus.st_ready), 32'd1);
        chk("after_tie_rf", 32'(bus.rf_ack), 32'd0);
        cycle();
        bus.st_valid = 0; bus.rf_req = 0; rd_addr = AW'(62);
        #1;
        chk("done_cleared", 32'(bus.rf_done), 32'd0);
        chk("mem62", rd_data, 32'h10);
        cycle();

        // Reset during beat 2 of a 4-beat burst, then a single-beat burst.
        bus.rf_req = 1; bus.rf_addr = AW'(20); bus.rf_len = LW'(3);
        #1 chk("rb_ack", 32'(bus.rf_ack), 32'd1);
        cycle();
        bus.rf_req = 0; bus.rf_valid = 1; bus.rf_data = 32'hB0;
        cycle();
        bus.rf_data = 32'hB1;
        cycle();
        chk("rb_pending", 32'(ram_we_w), 32'd1);
        bus.rf_valid = 0;
        do_reset();
        cycle();
        rd_addr = AW'(20);
        #1 chk("rb_beat1_kept", rd_data, 32'hB0);
        rd_addr = AW'(21);
        #1 chk("rb_beat2_dropped", rd_data, 32'h1515_1515);
        bus.rf_req = 1; bus.rf_addr = AW'(40); bus.rf_len = LW'(0);
        #1 chk("len0_ack", 32'(bus.rf_ack), 32'd1);
        cycle();
        bus.rf_req = 0; bus.rf_valid = 1; bus.rf_data = 32'hC0;
        #1 chk("len0_busy", 32'(busy), 32'd1);
        cycle();
        bus.rf_valid = 0;
        #1;
        chk("len0_idle", 32'(busy), 32'd0);
        chk("len0_done", 32'(bus.rf_done), 32'd1);
        chk("len0_addr", 32'(ram_addr_w), 32'd40);
        cycle();

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset();
                cycle();
                rst = 1'b0;
                continue;
            end
            bus.st_valid = ($urandom_range(0, 2) == 0);
            bus.st_addr  = AW'($urandom_range(0, D - 1));
            bus.st_data  = $urandom;
            bus.rf_req   = ($urandom_range(0, 3) == 0);
            bus.rf_addr  = AW'($urandom_range(0, D - 1));
            bus.rf_len   = ($urandom_range(0, 3) == 0) ? LW'(0) : LW'($urandom_range(0, MB - 1));
            bus.rf_valid = ($urandom_range(0, 2) != 0);
            bus.rf_data  = $urandom;
            rd_addr      = $urandom_range(0, 1) ? m_wa : AW'($urandom_range(0, D - 1));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
